inv_addkey_mixcol: RTL

//  Decryption round back-half, directly downstream of the inverse S-box layer.

---
 rtl/inv_addkey_mixcol.sv | 121 ++++++++++++
 1 files changed

// File: rtl/inv_addkey_mixcol.sv
// Decryption round back-half: AddRoundKey on accept, then column-serial InvMixColumns
// (skipped on the final round), with valid/ready handshakes on both sides.
module inv_addkey_mixcol #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out
);

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t       state_reg, state_next;
    logic [1:0]   col_cnt_reg, col_cnt_next;
    logic [127:0] work_reg, work_next;

    logic [1:0]   lane_col [COLS_PER_CYCLE];
    logic [31:0]  lane_in  [COLS_PER_CYCLE];
    logic [31:0]  lane_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // 09/0b/0d/0e products are built from the x2, x4, x8 chain of each input byte.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] w, input logic [1:0] c);
        case (c)
            2'd0:    return w[127:96];
            2'd1:    return w[95:64];
            2'd2:    return w[63:32];
            default: return w[31:0];
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_lane
            assign lane_col[gi] = col_cnt_reg + 2'(gi);
            assign lane_in[gi]  = get_col(work_reg, lane_col[gi]);
            assign lane_out[gi] = inv_mix_col(lane_in[gi]);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        col_cnt_next = col_cnt_reg;
        work_next    = work_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next    = state_in ^ round_key;
                    col_cnt_next = 2'd0;
                    state_next   = last_round ? DONE : MIX;
                end
            end
            MIX: begin
                for (int c = 0; c < 4; c++) begin
                    for (int l = 0; l < COLS_PER_CYCLE; l++) begin
                        if (lane_col[l] == 2'(c))
                            work_next[127-32*c -: 32] = lane_out[l];
                    end
                end
                // The counter wraps to zero once the final group of columns is written.
                col_cnt_next = col_cnt_reg + 2'(COLS_PER_CYCLE);
                if (col_cnt_reg == 2'(4 - COLS_PER_CYCLE))
                    state_next = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            col_cnt_reg <= 2'd0;
            work_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            col_cnt_reg <= col_cnt_next;
            work_reg    <= work_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign state_out = (state_reg == DONE) ? work_reg : '0;

endmodule
